// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch bus controller.
//   ifc_state_e   : controller state encoding (3 bits)
//   IFC_SIZE_WORD : bus transfer size code for a 32-bit word
//   NOP_INSTR     : word presented to the datapath when nothing was fetched
package inst_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    IFC_IDLE    = 3'd0,
    IFC_REQ     = 3'd1,
    IFC_WAIT    = 3'd2,
    IFC_HOLD    = 3'd3,
    IFC_DISCARD = 3'd4
  } ifc_state_e;

  localparam logic [1:0]  IFC_SIZE_WORD = 2'b10;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  // Instruction fetches must be word aligned; anything else is an AdEL
  // that the datapath raises on its own from pcF.
  function automatic logic isWordAligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_flopenrc.sv
// Enabled register with synchronous clear and asynchronous active-low reset.
//   clk : clock          rst : async reset, active low (q <- 0)
//   en  : load d         clr : synchronous clear (q <- 0), wins over en
//   d   : data in        q   : data out
module inst_fetch_ctrl_flopenrc #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage bus controller between the PC register and the instruction
// cache port. Issues one request per fetch PC, buffers the returned word
// until the datapath takes it, and drains stale responses after a redirect.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   pcF               : fetch PC from the datapath
//   stall_i           : datapath cannot accept a new instruction
//   flush_i           : exception/ERET redirect (PC loads new target this edge)
//   instrF            : instruction for pcF, valid when stallreq_from_if = 0
//   stallreq_from_if  : no instruction is ready for pcF
//   is_clear          : stale response being drained, PC must hold
//   i_data_ok         : one-cycle pulse when a live word is captured
//   IF_pc             : address of the last accepted request
//   inst_req, inst_wr, inst_size, inst_addr : bus request side
//   inst_addr_ok, inst_data_ok, inst_rdata  : bus response side
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] instrF,
  output logic        stallreq_from_if,
  output logic        is_clear,
  output logic        i_data_ok,
  output logic [31:0] IF_pc,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata
);

  ifc_state_e  state;
  logic        flushPend;
  logic [31:0] reqPc;
  logic        reqQ;
  logic        dataOkQ;
  logic [31:0] bufQ;

  logic pcAligned;
  logic addrAccept;
  logic capture;
  logic enterReq;
  logic misalignEntry;

  assign pcAligned  = isWordAligned(pcF);
  assign addrAccept = (state == IFC_REQ) && inst_addr_ok;
  // A word returned together with a flush belongs to the old path.
  assign capture    = (state == IFC_WAIT) && inst_data_ok && !flush_i;

  // Edges on which a new fetch for pcF starts. Every path into REQ goes
  // through here so that req_pc is always latched from the current pcF.
  always_comb begin
    enterReq = 1'b0;
    case (state)
      IFC_IDLE:    enterReq = 1'b1;
      IFC_WAIT:    enterReq = flush_i && inst_data_ok;
      IFC_HOLD:    enterReq = flush_i || !stall_i;
      IFC_DISCARD: enterReq = inst_data_ok;
      default:     enterReq = 1'b0;
    endcase
  end

  // A misaligned PC never reaches the bus: jump straight to HOLD with a NOP.
  assign misalignEntry = enterReq && !pcAligned;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IFC_IDLE;
      flushPend <= 1'b0;
      reqPc     <= 32'h0;
      reqQ      <= 1'b0;
      dataOkQ   <= 1'b0;
    end else begin
      dataOkQ <= capture;
      if (enterReq) begin
        // Only DISCARD can have flushPend set; leaving it ends the drain.
        flushPend <= 1'b0;
        if (pcAligned) begin
          state <= IFC_REQ;
          reqPc <= pcF;
          reqQ  <= 1'b1;
        end else begin
          state <= IFC_HOLD;
          reqQ  <= 1'b0;
        end
      end else begin
        case (state)
          IFC_REQ: begin
            // data_ok here is a bus protocol error and is ignored.
            if (inst_addr_ok) begin
              reqQ  <= 1'b0;
              state <= (flush_i || flushPend) ? IFC_DISCARD : IFC_WAIT;
            end else if (flush_i) begin
              // Request cannot be withdrawn; remember to drop its response.
              flushPend <= 1'b1;
            end
          end
          IFC_WAIT: begin
            if (capture) begin
              state <= IFC_HOLD;
            end else if (flush_i) begin
              state <= IFC_DISCARD;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  inst_fetch_ctrl_flopenrc #(
    .Width (32)
  ) u_buf (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .clr (misalignEntry),
    .d   (inst_rdata),
    .q   (bufQ)
  );

  inst_fetch_ctrl_flopenrc #(
    .Width (32)
  ) u_if_pc (
    .clk (clk),
    .rst (rst),
    .en  (addrAccept),
    .clr (1'b0),
    .d   (reqPc),
    .q   (IF_pc)
  );

  assign instrF           = (state == IFC_HOLD) ? bufQ : NOP_INSTR;
  assign stallreq_from_if = (state != IFC_HOLD);
  assign is_clear         = (state == IFC_DISCARD);
  assign i_data_ok        = dataOkQ;
  assign inst_req         = reqQ;
  assign inst_addr        = reqPc;
  assign inst_wr          = 1'b0;
  assign inst_size        = IFC_SIZE_WORD;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pcF;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] instrF;
  logic        stallreq_from_if;
  logic        is_clear;
  logic        i_data_ok;
  logic [31:0] IF_pc;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  int checks = 0;
  int passes = 0;

  inst_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .pcF              (pcF),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .instrF           (instrF),
    .stallreq_from_if (stallreq_from_if),
    .is_clear         (is_clear),
    .i_data_ok        (i_data_ok),
    .IF_pc            (IF_pc),
    .inst_req         (inst_req),
    .inst_wr          (inst_wr),
    .inst_size        (inst_size),
    .inst_addr        (inst_addr),
    .inst_addr_ok     (inst_addr_ok),
    .inst_data_ok     (inst_data_ok),
    .inst_rdata       (inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: a pending address phase, an outstanding data
  // phase, whether that transaction is poisoned by a redirect, and whether a
  // word is ready for the datapath.
  logic        mStarted, mReq, mOut, mStale, mHave, mPulse;
  logic [31:0] mAddr, mWord, mIfPc;

  always @(posedge clk or negedge rst) begin : model
    logic        started, req, out, stale, have, pulse, issue;
    logic [31:0] addr, word, ifpc;
    if (!rst) begin
      mStarted <= 1'b0; mReq <= 1'b0; mOut <= 1'b0; mStale <= 1'b0;
      mHave <= 1'b0; mPulse <= 1'b0; mAddr <= '0; mWord <= '0; mIfPc <= '0;
    end else begin
      started = mStarted; req = mReq; out = mOut; stale = mStale; have = mHave;
      addr = mAddr; word = mWord; ifpc = mIfPc; pulse = 1'b0; issue = 1'b0;
      if (!started) begin
        started = 1'b1;
        issue = 1'b1;
      end else if (req) begin
        if (inst_addr_ok) begin
          req = 1'b0; out = 1'b1; ifpc = addr; stale = stale | flush_i;
        end else if (flush_i) begin
          stale = 1'b1;
        end
      end else if (out) begin
        if (inst_data_ok) begin
          out = 1'b0;
          if (stale || flush_i) begin
            stale = 1'b0;
            issue = 1'b1;
          end else begin
            have = 1'b1; word = inst_rdata; pulse = 1'b1;
          end
        end else if (flush_i) begin
          stale = 1'b1;
        end
      end else if (have) begin
        if (flush_i || !stall_i) issue = 1'b1;
      end
      if (issue) begin
        if (pcF[1:0] == 2'b00) begin
          have = 1'b0; req = 1'b1; addr = pcF;
        end else begin
          have = 1'b1; word = 32'h0;
        end
      end
      mStarted <= started; mReq <= req; mOut <= out; mStale <= stale; mHave <= have;
      mPulse <= pulse; mAddr <= addr; mWord <= word; mIfPc <= ifpc;
    end
  end

  always @(negedge clk) begin
    chk("m.instrF", instrF, mHave ? mWord : 32'h0);
    chk("m.stallreq", {31'h0, stallreq_from_if}, {31'h0, !mHave});
    chk("m.is_clear", {31'h0, is_clear}, {31'h0, mOut && mStale});
    chk("m.i_data_ok", {31'h0, i_data_ok}, {31'h0, mPulse});
    chk("m.inst_req", {31'h0, inst_req}, {31'h0, mReq});
    chk("m.inst_addr", inst_addr, mAddr);
    chk("m.IF_pc", IF_pc, mIfPc);
    chk("m.inst_wr", {31'h0, inst_wr}, 32'h0);
    chk("m.inst_size", {30'h0, inst_size}, 32'h2);
  end

  // Apply one cycle of inputs, then return 1 time unit after the edge.
  task automatic cyc(input logic aok, input logic dok, input logic [31:0] rd,
                     input logic fl, input logic st, input logic [31:0] pc);
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
    flush_i = fl; stall_i = st; pcF = pc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; pcF = 32'hBFC0_0000; stall_i = 1'b0; flush_i = 1'b0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.instrF", instrF, 32'h0);
    chk("rst.stallreq", {31'h0, stallreq_from_if}, 32'h1);
    chk("rst.inst_req", {31'h0, inst_req}, 32'h0);
    chk("rst.inst_addr", inst_addr, 32'h0);
    chk("rst.IF_pc", IF_pc, 32'h0);
    chk("rst.is_clear", {31'h0, is_clear}, 32'h0);
    rst = 1'b1;

    // Best-case fetch from the boot vector.
    cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0000);
    chk("boot.req", {31'h0, inst_req}, 32'h1);
    chk("boot.addr", inst_addr, 32'hBFC0_0000);
    cyc(1, 0, 32'h0, 0, 1, 32'hBFC0_0000);
    chk("boot.ifpc", IF_pc, 32'hBFC0_0000);
    chk("boot.req_drop", {31'h0, inst_req}, 32'h0);
    cyc(0, 1, 32'h3C08_BFC0, 0, 1, 32'hBFC0_0000);
    chk("boot.instr", instrF, 32'h3C08_BFC0);
    chk("boot.stallreq", {31'h0, stallreq_from_if}, 32'h0);
    chk("boot.dok", {31'h0, i_data_ok}, 32'h1);

    // Held by datapath stall.
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0000);
      chk("hold.instr", instrF, 32'h3C08_BFC0);
      chk("hold.req", {31'h0, inst_req}, 32'h0);
    end
    cyc(0, 0, 32'h0, 0, 0, 32'hBFC0_0004);
    chk("next.req", {31'h0, inst_req}, 32'h1);
    chk("next.addr", inst_addr, 32'hBFC0_0004);

    // Flush while waiting for data; response arrives 3 cycles later.
    cyc(1, 0, 32'h0, 0, 1, 32'hBFC0_0004);
    cyc(0, 0, 32'h0, 1, 1, 32'hBFC0_0380);
    chk("wflush.clr1", {31'h0, is_clear}, 32'h1);
    cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0380);
    chk("wflush.clr2", {31'h0, is_clear}, 32'h1);
    cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0380);
    chk("wflush.clr3", {31'h0, is_clear}, 32'h1);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 1, 32'hBFC0_0380);
    chk("wflush.dok", {31'h0, i_data_ok}, 32'h0);
    chk("wflush.req", {31'h0, inst_req}, 32'h1);
    chk("wflush.addr", inst_addr, 32'hBFC0_0380);

    // Flush during the address phase with addr_ok withheld two cycles.
    cyc(0, 0, 32'h0, 1, 1, 32'h8000_0180);
    chk("rflush.addr1", inst_addr, 32'hBFC0_0380);
    chk("rflush.clr1", {31'h0, is_clear}, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'h8000_0180);
    chk("rflush.addr2", inst_addr, 32'hBFC0_0380);
    chk("rflush.req2", {31'h0, inst_req}, 32'h1);
    cyc(1, 0, 32'h0, 0, 1, 32'h8000_0180);
    chk("rflush.discard", {31'h0, is_clear}, 32'h1);
    chk("rflush.ifpc", IF_pc, 32'hBFC0_0380);
    cyc(0, 1, 32'h1111_2222, 0, 1, 32'h8000_0180);
    chk("rflush.newaddr", inst_addr, 32'h8000_0180);
    chk("rflush.dok", {31'h0, i_data_ok}, 32'h0);
    cyc(1, 0, 32'h0, 0, 1, 32'h8000_0180);
    cyc(0, 1, 32'h1234_5678, 0, 1, 32'h8000_0180);
    chk("rflush.instr", instrF, 32'h1234_5678);
    chk("rflush.ifpc2", IF_pc, 32'h8000_0180);

    // Flush coincident with data_ok.
    cyc(0, 0, 32'h0, 0, 0, 32'h8000_0184);
    cyc(1, 0, 32'h0, 0, 1, 32'h8000_0184);
    cyc(0, 1, 32'hAAAA_5555, 1, 1, 32'h8000_0200);
    chk("cflush.dok", {31'h0, i_data_ok}, 32'h0);
    chk("cflush.clr", {31'h0, is_clear}, 32'h0);
    chk("cflush.addr", inst_addr, 32'h8000_0200);
    cyc(1, 0, 32'h0, 0, 1, 32'h8000_0200);
    cyc(0, 1, 32'h2402_0001, 0, 1, 32'h8000_0200);
    chk("cflush.instr", instrF, 32'h2402_0001);

    // Misaligned PC: no bus request, NOP held.
    cyc(0, 0, 32'h0, 0, 0, 32'hBFC0_0002);
    chk("mis.req", {31'h0, inst_req}, 32'h0);
    chk("mis.instr", instrF, 32'h0);
    chk("mis.stallreq", {31'h0, stallreq_from_if}, 32'h0);
    cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0002);

    // Flush and stall together from HOLD; data_ok during REQ is ignored.
    cyc(0, 0, 32'h0, 1, 1, 32'hBFC0_0010);
    chk("fs.addr", inst_addr, 32'hBFC0_0010);
    cyc(0, 1, 32'h5555_5555, 0, 1, 32'hBFC0_0010);
    chk("fs.req", {31'h0, inst_req}, 32'h1);
    chk("fs.dok", {31'h0, i_data_ok}, 32'h0);
    cyc(1, 0, 32'h0, 0, 1, 32'hBFC0_0010);
    cyc(0, 1, 32'h8C08_0004, 0, 1, 32'hBFC0_0010);
    chk("fs.instr", instrF, 32'h8C08_0004);

    // Reset in the middle of a transaction, then a late data_ok.
    cyc(0, 0, 32'h0, 0, 0, 32'hBFC0_0014);
    cyc(1, 0, 32'h0, 0, 1, 32'hBFC0_0014);
    #1 rst = 1'b0;
    #1;
    chk("mrst.req", {31'h0, inst_req}, 32'h0);
    chk("mrst.ifpc", IF_pc, 32'h0);
    chk("mrst.stallreq", {31'h0, stallreq_from_if}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc(0, 1, 32'hDEAD_0000, 0, 1, 32'hBFC0_0018);
    chk("late.req", {31'h0, inst_req}, 32'h1);
    chk("late.addr", inst_addr, 32'hBFC0_0018);
    cyc(0, 1, 32'hDEAD_0001, 0, 1, 32'hBFC0_0018);
    chk("late.dok", {31'h0, i_data_ok}, 32'h0);
    cyc(1, 0, 32'h0, 0, 1, 32'hBFC0_0018);
    cyc(0, 1, 32'hAFBF_0010, 0, 1, 32'hBFC0_0018);
    chk("late.instr", instrF, 32'hAFBF_0010);
    chk("late.ifpc", IF_pc, 32'hBFC0_0018);
    cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0018);
    cyc(0, 0, 32'h0, 0, 1, 32'hBFC0_0018);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
